// File: rtl/comma_aligner_pkg.sv
// Shared 8b/10b constants, FSM state type and small helpers for the comma aligner.
package comma_aligner_pkg;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;
  localparam logic [6:0] COMMA_P   = 7'b0011111;
  localparam logic [6:0] COMMA_N   = 7'b1100000;
  localparam logic [5:0] K28_6B_N  = 6'b001111;
  localparam logic [5:0] K28_6B_P  = 6'b110000;

  typedef enum logic [1:0] {
    StHunt,
    StVerify,
    StLocked
  } state_e;

  // True when the abcdei sub-block is one of the two K28 encodings.
  function automatic logic is_k28(input logic [9:0] code);
    return (code[9:4] == K28_6B_N) || (code[9:4] == K28_6B_P);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt == 4'hF) ? cnt : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/comma_aligner_if.sv
// Raw-word input and aligned-symbol output bundle of the comma aligner.
interface comma_aligner_if;

  logic [9:0] rx_data;
  logic       rx_valid;
  logic [9:0] sym_out;
  logic       sym_k;
  logic       sym_valid;
  logic       locked;
  logic [3:0] align_offset;

  modport master (
    output rx_data, rx_valid,
    input  sym_out, sym_k, sym_valid, locked, align_offset
  );

  modport slave (
    input  rx_data, rx_valid,
    output sym_out, sym_k, sym_valid, locked, align_offset
  );

endinterface

// File: rtl/comma_finder.sv
// Combinational comma search over a 20-bit window; offset o tests win[19-o -: 7].
module comma_finder
  import comma_aligner_pkg::*;
(
  input  logic [19:0] win_i,
  output logic        hit_o,
  output logic [3:0]  hit_offset_o,
  output logic [9:0]  hit_vec_o
);

  always_comb begin
    hit_vec_o = '0;
    for (int o = 0; o < 10; o++) begin
      hit_vec_o[o] = (win_i[19-o -: 7] == COMMA_P) || (win_i[19-o -: 7] == COMMA_N);
    end
  end

  // Scan downwards so the lowest hitting offset is the last one written.
  always_comb begin
    hit_offset_o = '0;
    for (int o = 9; o >= 0; o--) begin
      if (hit_vec_o[o]) begin
        hit_offset_o = 4'(o);
      end
    end
  end

  assign hit_o = |hit_vec_o;

endmodule

// File: rtl/comma_aligner.sv
// Comma-based word aligner: HUNT/VERIFY/LOCKED FSM feeding a registered symbol output.
module comma_aligner
  import comma_aligner_pkg::*;
#(
  parameter int unsigned COMMA_CONFIRM = 3,
  parameter int unsigned LOSS_THRESH   = 4
) (
  input logic           clk,
  input logic           rst,
  comma_aligner_if.slave bus
);

  localparam logic [3:0] ConfirmCnt = 4'(COMMA_CONFIRM);
  localparam logic [3:0] LossCnt    = 4'(LOSS_THRESH);

  state_e     state_q, state_d;
  logic [9:0] prev_q;
  logic [3:0] conf_q, conf_d;
  logic [3:0] miss_q, miss_d;
  logic [3:0] off_q, off_d;
  logic [9:0] sym_out_q, sym_out_d;
  logic       sym_k_q, sym_k_d;
  logic       sym_valid_q, sym_valid_d;

  logic [19:0] win;
  logic        hit;
  logic [3:0]  hit_offset;
  logic [9:0]  hit_vec;
  logic        aligned_hit;
  logic [9:0]  cand;
  logic [3:0]  conf_inc;
  logic [3:0]  miss_inc;

  assign win = {prev_q, bus.rx_data};

  comma_finder u_finder (
    .win_i        (win),
    .hit_o        (hit),
    .hit_offset_o (hit_offset),
    .hit_vec_o    (hit_vec)
  );

  assign aligned_hit = hit_vec[off_q];
  assign conf_inc    = sat_inc(conf_q);
  assign miss_inc    = sat_inc(miss_q);

  always_comb begin
    cand = '0;
    for (int o = 0; o < 10; o++) begin
      if (off_q == 4'(o)) begin
        cand = win[19-o -: 10];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    conf_d  = conf_q;
    miss_d  = miss_q;
    off_d   = off_q;
    if (bus.rx_valid) begin
      case (state_q)
        StHunt: begin
          if (hit) begin
            off_d  = hit_offset;
            conf_d = 4'd1;
            if (ConfirmCnt <= 4'd1) begin
              state_d = StLocked;
              miss_d  = '0;
            end else begin
              state_d = StVerify;
            end
          end
        end
        StVerify: begin
          if (aligned_hit) begin
            conf_d = conf_inc;
            if (conf_inc >= ConfirmCnt) begin
              state_d = StLocked;
              miss_d  = '0;
            end
          end else if (hit) begin
            state_d = StHunt;
            conf_d  = '0;
          end
        end
        StLocked: begin
          // An aligned comma wins over a simultaneous misaligned one.
          if (aligned_hit) begin
            miss_d = '0;
          end else if (hit) begin
            miss_d = miss_inc;
            if (miss_inc >= LossCnt) begin
              state_d = StHunt;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_comb begin
    sym_out_d   = sym_out_q;
    sym_k_d     = sym_k_q;
    sym_valid_d = 1'b0;
    if (bus.rx_valid && (state_q == StLocked)) begin
      sym_out_d   = cand;
      sym_k_d     = is_k28(cand);
      sym_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHunt;
      prev_q      <= '0;
      conf_q      <= '0;
      miss_q      <= '0;
      off_q       <= '0;
      sym_out_q   <= '0;
      sym_k_q     <= 1'b0;
      sym_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= bus.rx_valid ? bus.rx_data : prev_q;
      conf_q      <= conf_d;
      miss_q      <= miss_d;
      off_q       <= off_d;
      sym_out_q   <= sym_out_d;
      sym_k_q     <= sym_k_d;
      sym_valid_q <= sym_valid_d;
    end
  end

  assign bus.sym_out      = sym_out_q;
  assign bus.sym_k        = sym_k_q;
  assign bus.sym_valid    = sym_valid_q;
  assign bus.locked       = (state_q == StLocked);
  assign bus.align_offset = off_q;

endmodule

// File: doc/comma_aligner.md
Name: comma_aligner

Overview:
- Upstream neighbour of the 8b/10b symbol decoder.
- Takes unaligned 10-bit parallel words from the deserializer and searches a 20-bit sliding window for the comma pattern. Once it is confident of the alignment, it emits symbol-aligned 10-bit codes.
- Raises a K28 flag with each code. That flag drives the decoder's k_in, and the aligned code drives its data_in.
- Bit order matches the decoder: bit 9 = first-received bit 'a'; [9:4] = abcdei; [3:0] = fghj.

Parameters:
- COMMA_CONFIRM, 3: consecutive same-offset commas needed to go from VERIFY to LOCKED (range 1..15).
- LOSS_THRESH, 4: consecutive misaligned commas in LOCKED that force a return to HUNT (range 1..15).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  10  raw deserialized word; bit 9 received earliest.
- rx_valid  in  1  rx_data is valid this cycle.
- sym_out  out  10  aligned 10b code, abcdei fghj in [9:0].
- sym_k  out  1  sym_out[9:4] is 001111 or 110000 (K28.x); feeds the decoder's k_in.
- sym_valid  out  1  sym_out/sym_k valid this cycle.
- locked  out  1  FSM is in LOCKED.
- align_offset  out  4  latched offset 0..9.

Interface decision (already decided): one clock, clk. Reset rst is synchronous and active-high.

Behaviour:
- Reset values: every output 0, prev_word 0, FSM in HUNT, all counters 0. A reset asserted mid-operation takes effect at the next edge regardless of state. There is no partial retention.
- Window: win[19:0] = {prev_word, rx_data}. prev_word <= rx_data on every rx_valid. Cycles with rx_valid=0 change nothing (FSM, counters, window) and drive sym_valid=0.
- Candidate at offset o (0..9): cand_o = win[19-o -: 10].
- Comma at o: win[19-o -: 7] == 7'b0011111 or 7'b1100000.
- If several offsets hit in one window, the lowest o wins (priority encode).
- HUNT:
  - On a comma at any offset: latch align_offset=o, set conf_cnt=1, go to VERIFY.
  - If COMMA_CONFIRM==1, go directly to LOCKED instead.
- VERIFY:
  - Comma at the latched offset: conf_cnt+1. When conf_cnt reaches COMMA_CONFIRM, go to LOCKED and clear miss_cnt.
  - Comma at any other offset (and none at the latched one): go to HUNT, clear conf_cnt.
  - No comma: hold.
- LOCKED:
  - Comma at the latched offset: miss_cnt=0.
  - Else, comma at another offset: miss_cnt+1. When miss_cnt reaches LOSS_THRESH, go to HUNT; locked falls on the same edge.
  - A comma at the latched offset takes priority over a simultaneous misaligned one.
  - No comma: miss_cnt holds.
- Counters are 4-bit and saturate; they never wrap.
- Output register, one-cycle latency: for an rx_valid word at edge n while in LOCKED (the state before edge n), the next edge loads:
  - sym_out = cand at align_offset;
  - sym_k = (cand[9:4] == 6'b001111 or 6'b110000);
  - sym_valid = 1.
- In HUNT or VERIFY, sym_valid=0. sym_out and sym_k hold their last value.
- locked and align_offset are registered outputs that follow the FSM state.
- The final confirming comma itself is not emitted; emission starts with the next valid word.

Decomposition:
- Shared package, 8b10b pkg:
  - K28_5_RDN = 10'b0011111010, K28_5_RDP = 10'b1100000101;
  - COMMA_P = 7'b0011111, COMMA_N = 7'b1100000;
  - K28_6B_N = 6'b001111, K28_6B_P = 6'b110000;
  - state enum {HUNT, VERIFY, LOCKED}.
- One sub-module, comma_finder: combinational. Input win[19:0]. Outputs hit (1 bit), hit_offset[3:0] (lowest-offset priority), and a per-offset hit vector[9:0] so the FSM can test the latched offset.

Test Plan:
- Aligned stream (offset 0) of alternating K28.5 RDN/RDP, rst low from cycle 2 -> locked rises after 3 commas, align_offset=0, sym_out alternates 0011111010/1100000101, sym_k=1, sym_valid=1 one cycle after each input.
- Same bitstream slipped by 3 bits, then a D21.5 symbol (1010101010) -> align_offset=3, lock after 3 commas, sym_out=1010101010 with sym_k=0.
- In LOCKED at offset 3, reslip the stream to offset 7 -> locked drops exactly on the 4th misaligned comma. The FSM then returns to HUNT and re-locks with align_offset=7.
- In VERIFY with conf_cnt=2, inject a comma at a different offset -> FSM returns to HUNT, locked never asserts, sym_valid stays 0.
- rx_valid held low for 5 cycles mid-lock -> no state or counter change, sym_valid=0 for those cycles, lock retained.
- Assert rst for one cycle while LOCKED -> next edge: locked=0, sym_valid=0, sym_out=0, align_offset=0, FSM in HUNT.
